// File: rtl/vseq_pkg.sv
// Shared definitions for the vector lane sequencer: default geometry, the
// controller state encoding and the lane-count clamp.
package vseq_pkg;

    localparam int VSEQ_LANES = 5;   // matches the 5-element vector register file
    localparam int VSEQ_W     = 32;  // lane data width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } vseq_state_t;

    // Requested lane count saturates at the lane count; 0 stays 0 (no-op write).
    function automatic logic [2:0] clamp_vsize(input logic [2:0] v, input logic [2:0] max_n);
        return (v > max_n) ? max_n : v;
    endfunction

endpackage

// File: rtl/vlane_sequencer_if.sv
// Bundle between the control unit / regfile / shared ALU and the sequencer.
//   start, vsize, wa_in : op request (sampled only while idle)
//   va, vb              : flattened source lanes, lane i at [i*W +: W]
//   alu_a, alu_b, alu_y : shared scalar ALU operands and combinational result
//   vwe, vwa, vsize_out : vector write strobe, destination, lane count
//   wd                  : flattened write data, lanes >= n forced to zero
//   busy, done          : core stall and one-cycle completion pulse
// master = surrounding datapath, slave = sequencer.
interface vlane_sequencer_if
    import vseq_pkg::*;
#(
    parameter int LANES = VSEQ_LANES,
    parameter int W     = VSEQ_W
);
    logic                 start;
    logic [2:0]           vsize;
    logic [3:0]           wa_in;
    logic [LANES*W-1:0]   va;
    logic [LANES*W-1:0]   vb;
    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic [W-1:0]         alu_y;
    logic                 vwe;
    logic [3:0]           vwa;
    logic [2:0]           vsize_out;
    logic [LANES*W-1:0]   wd;
    logic                 busy;
    logic                 done;

    modport master (
        output start, vsize, wa_in, va, vb, alu_y,
        input  alu_a, alu_b, vwe, vwa, vsize_out, wd, busy, done
    );

    modport slave (
        input  start, vsize, wa_in, va, vb, alu_y,
        output alu_a, alu_b, vwe, vwa, vsize_out, wd, busy, done
    );

endinterface

// File: rtl/vlane_sequencer.sv
// Runs one vector op across 1..LANES lanes through a single shared scalar
// ALU, one lane per cycle, then issues a single vector register write.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any op without writing
//   bus   : vlane_sequencer_if slave modport (request, ALU, write, status)
module vlane_sequencer
    import vseq_pkg::*;
#(
    parameter int LANES = VSEQ_LANES,
    parameter int W     = VSEQ_W
) (
    input  logic               clk,
    input  logic               reset,
    vlane_sequencer_if.slave   bus
);

    localparam logic [2:0] MAX_N = 3'(LANES);

    vseq_state_t state, state_nxt;

    logic [2:0]                 idx;
    logic [2:0]                 n_q;
    logic [3:0]                 wa_q;
    logic [LANES-1:0][W-1:0]    a_buf;
    logic [LANES-1:0][W-1:0]    b_buf;
    logic [LANES-1:0][W-1:0]    res;
    logic [LANES-1:0][W-1:0]    wd_l;
    logic [2:0]                 n_req;
    logic                       last_lane;

    assign n_req     = clamp_vsize(bus.vsize, MAX_N);
    assign last_lane = (idx == n_q - 3'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (n_req == 3'd0) ? WRITE : EXEC;
            EXEC:    if (last_lane) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            n_q   <= '0;
            wa_q  <= '0;
            a_buf <= '0;
            b_buf <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Snapshot operands so regfile writes during EXEC are invisible.
                    if (bus.start) begin
                        a_buf <= bus.va;
                        b_buf <= bus.vb;
                        wa_q  <= bus.wa_in;
                        n_q   <= n_req;
                        idx   <= '0;
                    end
                end
                EXEC: begin
                    res[idx] <= bus.alu_y;
                    if (!last_lane) idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Status and strobes decode registered state only; start never reaches them.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == WRITE);
    assign bus.vwe       = (state == WRITE) && (n_q != 3'd0);
    assign bus.vwa       = wa_q;
    assign bus.vsize_out = n_q;
    assign bus.alu_a     = (state == EXEC) ? a_buf[idx] : '0;
    assign bus.alu_b     = (state == EXEC) ? b_buf[idx] : '0;

    // Stale results from a longer earlier op are masked off above n.
    for (genvar i = 0; i < LANES; i++) begin : g_wd
        assign wd_l[i] = ((state == WRITE) && (3'(i) < n_q)) ? res[i] : '0;
    end

    assign bus.wd = wd_l;

endmodule

// File: tb/tb_vlane_sequencer.sv
module tb_vlane_sequencer;

    localparam int LANES = 5;
    localparam int W     = 32;

    logic clk;
    logic reset;

    vlane_sequencer_if #(.LANES(LANES), .W(W)) bus();

    vlane_sequencer #(.LANES(LANES), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared scalar ALU: adder.
    assign bus.alu_y = bus.alu_a + bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]        vs;
        logic [3:0]        wa;
        int                n;
        logic              vwe;
        logic [4:0][31:0]  wd;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [4:0][31:0] lanes5(int e0, int e1, int e2, int e3, int e4);
        logic [4:0][31:0] r;
        r[0] = 32'(e0); r[1] = 32'(e1); r[2] = 32'(e2); r[3] = 32'(e3); r[4] = 32'(e4);
        return r;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_operands();
        for (int i = 0; i < LANES; i++) begin
            bus.va[i*W +: W] = 32'd2;
            bus.vb[i*W +: W] = 32'(3 + i);
        end
    endtask

    // Issue one op from IDLE and check the EXEC trace, WRITE cycle and return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] vs, input logic [3:0] wa,
                          input int exp_n, input logic exp_vwe, input logic [4:0][31:0] exp_wd);
        int k;
        bus.start = 1'b1;
        bus.vsize = vs;
        bus.wa_in = wa;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 12) begin
            chk({tag, "_exec_busy"}, 160'(bus.busy), 160'd1);
            chk({tag, "_alu_a"}, 160'(bus.alu_a), 160'd2);
            chk({tag, "_alu_b"}, 160'(bus.alu_b), 160'(3 + k));
            k++;
            tick();
        end
        chk({tag, "_done_seen"}, 160'(bus.done), 160'd1);
        chk({tag, "_exec_cycles"}, 160'(k), 160'(exp_n));
        chk({tag, "_vwe"}, 160'(bus.vwe), 160'(exp_vwe));
        chk({tag, "_vwa"}, 160'(bus.vwa), 160'(wa));
        chk({tag, "_vsize_out"}, 160'(bus.vsize_out), 160'(exp_n));
        chk({tag, "_wd"}, 160'(bus.wd), 160'(exp_wd));
        chk({tag, "_write_busy"}, 160'(bus.busy), 160'd1);
        tick();
        chk({tag, "_idle_busy"}, 160'(bus.busy), 160'd0);
        chk({tag, "_idle_done"}, 160'(bus.done), 160'd0);
        chk({tag, "_idle_vwe"}, 160'(bus.vwe), 160'd0);
    endtask

    initial begin
        int dones;
        int act;

        tbl[0] = '{vs: 3'd5, wa: 4'd3,  n: 5, vwe: 1'b1, wd: lanes5(5, 6, 7, 8, 9)};
        tbl[1] = '{vs: 3'd2, wa: 4'd4,  n: 2, vwe: 1'b1, wd: lanes5(5, 6, 0, 0, 0)};
        tbl[2] = '{vs: 3'd0, wa: 4'd5,  n: 0, vwe: 1'b0, wd: lanes5(0, 0, 0, 0, 0)};
        tbl[3] = '{vs: 3'd7, wa: 4'd6,  n: 5, vwe: 1'b1, wd: lanes5(5, 6, 7, 8, 9)};
        tbl[4] = '{vs: 3'd1, wa: 4'd15, n: 1, vwe: 1'b1, wd: lanes5(5, 0, 0, 0, 0)};
        tbl[5] = '{vs: 3'd6, wa: 4'd7,  n: 5, vwe: 1'b1, wd: lanes5(5, 6, 7, 8, 9)};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.vsize = 3'd0;
        bus.wa_in = 4'd0;
        set_default_operands();
        tick();
        tick();
        chk("rst_busy",      160'(bus.busy),      160'd0);
        chk("rst_done",      160'(bus.done),      160'd0);
        chk("rst_vwe",       160'(bus.vwe),       160'd0);
        chk("rst_vwa",       160'(bus.vwa),       160'd0);
        chk("rst_vsize_out", 160'(bus.vsize_out), 160'd0);
        chk("rst_wd",        160'(bus.wd),        160'd0);
        chk("rst_alu_a",     160'(bus.alu_a),     160'd0);
        chk("rst_alu_b",     160'(bus.alu_b),     160'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++)
            run_op($sformatf("vec%0d", v), tbl[v].vs, tbl[v].wa, tbl[v].n, tbl[v].vwe, tbl[v].wd);

        // Start during busy must be ignored: one done, write to reg 3.
        bus.start = 1'b1; bus.vsize = 3'd5; bus.wa_in = 4'd3;
        tick();                                  // T1
        bus.start = 1'b0;
        tick();                                  // T2
        bus.start = 1'b1; bus.wa_in = 4'd9; bus.vsize = 3'd2;
        tick();                                  // T3
        bus.start = 1'b0; bus.wa_in = 4'd3;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) begin
                dones++;
                chk("busy_start_vwa", 160'(bus.vwa), 160'd3);
                chk("busy_start_wd",  160'(bus.wd),  160'(lanes5(5, 6, 7, 8, 9)));
            end
            tick();
        end
        chk("busy_start_done_count", 160'(dones), 160'd1);

        // Operand snapshot: source A trashed at T2, results unchanged.
        bus.start = 1'b1; bus.vsize = 3'd5; bus.wa_in = 4'd2;
        tick();                                  // T1
        bus.start = 1'b0;
        tick();                                  // T2
        bus.va = '1;
        for (int c = 0; c < 10 && !bus.done; c++) tick();
        chk("snap_done", 160'(bus.done), 160'd1);
        chk("snap_wd",   160'(bus.wd),   160'(lanes5(5, 6, 7, 8, 9)));
        tick();
        set_default_operands();
        tick();

        // Reset in the middle of a 5-lane op: no write, no done.
        act = 0;
        bus.start = 1'b1; bus.vsize = 3'd5; bus.wa_in = 4'd3;
        tick();                                  // T1
        bus.start = 1'b0;
        if (bus.vwe || bus.done) act++;
        tick();                                  // T2
        if (bus.vwe || bus.done) act++;
        tick();                                  // T3
        if (bus.vwe || bus.done) act++;
        reset = 1'b1;
        tick();                                  // T4
        chk("mid_rst_busy",  160'(bus.busy),  160'd0);
        chk("mid_rst_done",  160'(bus.done),  160'd0);
        chk("mid_rst_vwe",   160'(bus.vwe),   160'd0);
        chk("mid_rst_wd",    160'(bus.wd),    160'd0);
        chk("mid_rst_alu_a", 160'(bus.alu_a), 160'd0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.vwe || bus.done || bus.busy) act++;
        end
        chk("mid_rst_no_activity", 160'(act), 160'd0);

        // Recovery after abort.
        run_op("recover", tbl[0].vs, tbl[0].wa, tbl[0].n, tbl[0].vwe, tbl[0].wd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vlane_sequencer.md
Name: vlane_sequencer

Overview:
- Multi-cycle controller that runs one vector operation over 1..5 lanes using a single shared scalar ALU, one lane per cycle.
- Sits between the control unit and the vector register file.
- On start, snapshots both source vectors, steps the ALU across the active lanes and buffers the results. It then issues one vector write (we3 plus five write-data words) and stalls the core while busy.

Parameters:
- LANES, 5, number of vector lanes; matches the 5-element vector register file.
- W, 32, lane data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a vector op; sampled only in IDLE.
- vsize  in  3  active lane count at start (1..5).
- wa_in  in  4  destination vector register, latched at start.
- va  in  LANES*W  source A lanes, flattened; lane i at bits [i*W +: W].
- vb  in  LANES*W  source B lanes, flattened, same layout.
- alu_a  out  W  operand A to shared ALU.
- alu_b  out  W  operand B to shared ALU.
- alu_y  in  W  combinational ALU result for the current alu_a/alu_b.
- vwe  out  1  vector write enable; drives regfile we3/vector_op.
- vwa  out  4  vector write address; drives regfile wa3.
- vsize_out  out  3  latched lane count; drives regfile vector_size during the write.
- wd  out  LANES*W  write data lanes, flattened; lane i feeds wd(i+1).
- busy  out  1  stall to the core; high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, lane index=0.
  - All operand/result buffers cleared to 0; vwa=0, vsize_out=0.
  - Outputs: vwe=0, busy=0, done=0, alu_a=alu_b=0, wd=0.
  - Reset mid-operation aborts without any write.
- States: IDLE, EXEC, WRITE.
- IDLE:
  - alu_a/alu_b=0.
  - On start=1, latch va, vb, wa_in and n = clamp(vsize).
  - Clamp rule: vsize>5 gives 5; vsize=0 gives 0.
  - n>=1: go to EXEC with idx=0.
  - n=0: go to WRITE with vwe suppressed; done still pulses.
- EXEC:
  - alu_a=A[idx], alu_b=B[idx]; at the clock edge res[idx] <= alu_y.
  - If idx==n-1, go to WRITE; else idx++.
  - Exactly n EXEC cycles.
- WRITE (one cycle):
  - vwe=1 when n>=1; vwa=latched wa; vsize_out=n.
  - wd lanes 0..n-1 = res; lanes >= n = 0.
  - done=1 in this cycle; next state IDLE.
- Latency: start sampled at edge T0. EXEC occupies cycles T1..Tn. WRITE/done is cycle Tn+1. The next start is accepted at the edge ending Tn+1.
- busy=1 in EXEC and WRITE; start during busy is ignored, with no queuing.
- Operands are snapshotted at start, so regfile changes during EXEC do not affect results.
- The write lands at the end of WRITE; a back-to-back start in the following IDLE cycle sees the updated register.
- vwe, done and busy are registered-state decodes only; no combinational path from start to them.
- Lane index width: 3 bits; never exceeds LANES-1.

Decomposition:
- Shared package vseq_pkg holds:
  - state enum (IDLE=2'd0, EXEC=2'd1, WRITE=2'd2);
  - LANES and W defaults;
  - the vsize clamp function.
- No sub-module needed; the operand/result buffers are plain register arrays inside the block. If the buffer is split out, the sub-module is vlane_buf (LANES x W register array with indexed write and flattened read).

Test Plan:
- Add, 5 lanes. A=all 2, B={3,4,5,6,7}, alu_y=a+b, vsize=5, wa_in=3, start at T0 -> busy T1..T6; alu_a=2 and alu_b=3..7 over T1..T5; T6 vwe=1, vwa=3, wd={5,6,7,8,9}, done=1; T7 busy=0.
- Partial vector. vsize=2, same operands -> EXEC 2 cycles; T3 wd={5,6,0,0,0}, vsize_out=2, vwe=1.
- Boundary sizes:
  - vsize=0 -> T1 done=1, vwe=0, no ALU activity.
  - vsize=7 -> behaves exactly as vsize=5.
- Start while busy. Second start at T2 with wa_in=9 -> ignored; write goes to reg 3; only one done pulse.
- Snapshot. va changed to all 0xFFFFFFFF at T2 -> results still {5,6,7,8,9}.
- Reset mid-op. reset=1 at T3 of a 5-lane op -> T4 state IDLE, busy=0, vwe never asserted, done never asserted, wd=0.
